// File: rtl/risc_bus_pkg.sv
// Shared bus definitions for the core-side store path: default widths,
// the MMIO decode window and the drain state encoding.
package risc_bus_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] MMIO_MASK_DEF = 32'hF000_0000;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sync_fifo_p.sv
// Small synchronous FIFO with wrapping pointers and registered count/full/empty.
// A push into a full FIFO is taken only when a pop frees the head slot in the same cycle.
module sync_fifo_p #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     accept,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the AW-bit increment wraps on its own
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata  = mem_q[rd_ptr_q];
  assign accept = do_push;
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/mmio_store_buffer.sv
// Posted-write buffer between the core store port and a slower MMIO bus.
// Define MMIO_STORE_BUF_FILTER_EN to buffer only stores that hit the MMIO window.
module mmio_store_buffer
  import risc_bus_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF),
  parameter logic [ADDR_W-1:0] MMIO_MASK = ADDR_W'(MMIO_MASK_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_we,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e               state_q, state_d;
  logic                       ovf_q, ovf_d;
  logic                       qualify, push, pop, accept;
  logic [ADDR_W+DATA_W-1:0]   head;

`ifdef MMIO_STORE_BUF_FILTER_EN
  assign qualify = ((st_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));
`else
  logic unused_window;
  assign unused_window = ^(MMIO_BASE & MMIO_MASK);
  assign qualify       = 1'b1;
`endif

  assign push = st_we & qualify;
  assign pop  = bus_valid & bus_ready;

  sync_fifo_p #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wdata  ({st_addr, st_data}),
    .rdata  (head),
    .accept (accept),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = PRESENT;
      PRESENT: if (pop && !push && count == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A dropped store outranks a same-cycle clear so no loss goes unreported
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)          ovf_d = 1'b0;
    if (push && !accept)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset, so the head is masked until something is presented
  assign bus_valid = (state_q == PRESENT);
  assign bus_addr  = bus_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign bus_data  = bus_valid ? head[DATA_W-1:0] : '0;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Scoreboard bench for mmio_store_buffer: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted bus transfer.
module tb_mmio_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_we;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        ovf_clr;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];

  mmio_store_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_we     (st_we),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic expect_accept);
    st_we   = 1'b1;
    st_addr = a;
    st_data = d;
    if (expect_accept) sb.push_back({a, d});
  endtask

  // Monitor: the beat visible at negedge with ready high transfers on the next edge
  always @(negedge clk) begin
    if (rst_n && bus_valid && bus_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat got=%h expected=none", {bus_addr, bus_data});
      end else begin
        chk("beat", {bus_addr, bus_data}, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] acc_mask;
    acc_mask = 12'b0101_0111_1111;

    rst_n = 1'b0; st_we = 1'b1; st_addr = 32'h8000_0004; st_data = 32'h1111_2222;
    bus_ready = 1'b1; ovf_clr = 1'b0;
    cyc(); cyc();
    chk("rst_valid", {63'd0, bus_valid}, 64'd0);
    chk("rst_addr",  {32'd0, bus_addr}, 64'd0);
    chk("rst_data",  {32'd0, bus_data}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full",  {63'd0, full}, 64'd0);
    chk("rst_ovf",   {63'd0, ovf}, 64'd0);
    st_we = 1'b0; bus_ready = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_empty", {63'd0, empty}, 64'd1);
    chk("post_rst_valid", {63'd0, bus_valid}, 64'd0);

    // Single store, held under back-pressure
    drive(32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    cyc();
    st_we = 1'b0;
    chk("single_valid", {63'd0, bus_valid}, 64'd1);
    chk("single_head", {bus_addr, bus_data}, {32'h8000_0010, 32'hDEAD_BEEF});
    chk("single_count", {61'd0, count}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_head", {bus_addr, bus_data}, {32'h8000_0010, 32'hDEAD_BEEF});
      chk("hold_valid", {63'd0, bus_valid}, 64'd1);
    end
    // Push and pop together at count 1: new entry becomes head
    bus_ready = 1'b1;
    drive(32'h8000_0014, 32'h1234_5678, 1'b1);
    cyc();
    st_we = 1'b0;
    chk("c1_pushpop_count", {61'd0, count}, 64'd1);
    chk("c1_pushpop_head", {bus_addr, bus_data}, {32'h8000_0014, 32'h1234_5678});
    cyc();
    bus_ready = 1'b0;
    chk("single_drained", {63'd0, empty}, 64'd1);

    // Fill and overflow; fifth store coincides with ovf_clr, set must win
    for (int i = 1; i <= 5; i++) begin
      drive(32'h8000_0100 + 32'(i * 4), 32'(i), i <= 4);
      ovf_clr = (i == 5);
      cyc();
    end
    st_we = 1'b0; ovf_clr = 1'b0;
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_count", {61'd0, count}, 64'd4);
    chk("fill_ovf", {63'd0, ovf}, 64'd1);
    bus_ready = 1'b1;
    repeat (4) cyc();
    bus_ready = 1'b0;
    chk("fill_drained", {63'd0, empty}, 64'd1);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {63'd0, ovf}, 64'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_0300 + 32'(i * 4), 32'hA0 + 32'(i), 1'b1);
      cyc();
    end
    st_we = 1'b0;
    chk("pp_full", {63'd0, full}, 64'd1);
    bus_ready = 1'b1;
    drive(32'h8000_0310, 32'hA4, 1'b1);
    cyc();
    st_we = 1'b0;
    chk("pp_count", {61'd0, count}, 64'd4);
    chk("pp_ovf", {63'd0, ovf}, 64'd0);
    repeat (4) cyc();
    bus_ready = 1'b0;
    chk("pp_drained", {63'd0, empty}, 64'd1);

    // Twelve back-to-back stores with ready toggling 1,0,...: slots 7,9,11 overflow
    for (int t = 0; t < 12; t++) begin
      bus_ready = (t % 2 == 0);
      drive(32'h8000_0200 + 32'(t * 4), 32'h100 + 32'(t), acc_mask[t]);
      cyc();
      chk("b2b_count_le_depth", {63'd0, count <= 3'd4}, 64'd1);
    end
    st_we = 1'b0;
    chk("b2b_ovf", {63'd0, ovf}, 64'd1);
    bus_ready = 1'b1;
    repeat (6) cyc();
    bus_ready = 1'b0;
    chk("b2b_drained", {63'd0, empty}, 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;

`ifdef MMIO_STORE_BUF_FILTER_EN
    drive(32'h0000_0100, 32'h5555_0000, 1'b0);
    cyc();
    st_we = 1'b0;
    chk("filt_ignored_count", {61'd0, count}, 64'd0);
    chk("filt_ignored_ovf", {63'd0, ovf}, 64'd0);
    drive(32'h8000_0100, 32'h5555_0001, 1'b1);
    cyc();
    st_we = 1'b0;
    chk("filt_taken_count", {61'd0, count}, 64'd1);
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
`endif

    // Reset mid-drain: one beat completes, the remaining two are discarded
    for (int i = 0; i < 3; i++) begin
      drive(32'h8000_0400 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1);
      cyc();
    end
    st_we = 1'b0;
    chk("md_count", {61'd0, count}, 64'd3);
    bus_ready = 1'b1;
    cyc();
    rst_n = 1'b0;
    sb.delete();
    #2;
    chk("md_rst_empty", {63'd0, empty}, 64'd1);
    chk("md_rst_valid", {63'd0, bus_valid}, 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("md_after_empty", {63'd0, empty}, 64'd1);
    chk("md_after_count", {61'd0, count}, 64'd0);
    bus_ready = 1'b0;

    cyc();
    chk("scoreboard_left", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
